// File: rtl/tour_cmd_seq_pkg.sv
// Shared types and constants for the knight-tour command sequencer.
// Optional build macro: TOUR_ABORT_EN (UART abort of a running tour).
package tour_cmd_pkg;

  // Sequencer states: pass-through idle, then two legs per move with a
  // completion wait after each leg.
  typedef enum logic [2:0] {
    IDLE,
    VERT,
    WAIT_V,
    HORZ,
    WAIT_H
  } state_t;

  // cmd_proc headings
  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  // cmd_proc opcodes
  localparam logic [3:0] OP_MOVE    = 4'h2;
  localparam logic [3:0] OP_FANFARE = 4'h3;
  localparam logic [3:0] OP_ABORT   = 4'hF;

  // Response bytes returned to the UART wrapper
  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_POS  = 8'h5A;

  // Assemble a cmd_proc command word: opcode, heading, squares.
  function automatic logic [15:0] mk_cmd(input logic [3:0] op,
                                         input logic [7:0] hdg,
                                         input logic [3:0] sq);
    return {op, hdg, sq};
  endfunction

endpackage

// File: rtl/tour_cmd_seq_if.sv
// Bus bundle between the tour sequencer and its neighbours (tour logic,
// move store, UART_wrapper, cmd_proc). The master modport is the
// sequencer side; the slave modport is the surrounding environment.
interface tour_cmd_seq_if;

  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  modport master (
    input  start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    output mv_indx, clr_cmd_rdy_UART, cmd, cmd_rdy, resp
  );

  modport slave (
    output start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    input  mv_indx, clr_cmd_rdy_UART, cmd, cmd_rdy, resp
  );

endinterface

// File: rtl/tour_move_decode.sv
// Translates a one-hot knight move into its vertical and horizontal
// cmd_proc legs. Multiple set bits resolve to the lowest one; an all-zero
// move is flagged invalid so the sequencer can skip it.
module tour_move_decode
  import tour_cmd_pkg::*;
(
  input  logic [7:0]  move_i,
  output logic [15:0] vert_cmd_o,
  output logic [15:0] horz_cmd_o,
  output logic        valid_o
);

  // Lowest-set-bit priority decode of the move table
  always_comb begin
    vert_cmd_o = '0;
    horz_cmd_o = '0;
    valid_o    = |move_i;
    casez (move_i)
      8'b???????1: begin
        vert_cmd_o = mk_cmd(OP_MOVE,    HDG_N, 4'd2);
        horz_cmd_o = mk_cmd(OP_FANFARE, HDG_E, 4'd1);
      end
      8'b??????10: begin
        vert_cmd_o = mk_cmd(OP_MOVE,    HDG_N, 4'd2);
        horz_cmd_o = mk_cmd(OP_FANFARE, HDG_W, 4'd1);
      end
      8'b?????100: begin
        vert_cmd_o = mk_cmd(OP_MOVE,    HDG_N, 4'd1);
        horz_cmd_o = mk_cmd(OP_FANFARE, HDG_W, 4'd2);
      end
      8'b????1000: begin
        vert_cmd_o = mk_cmd(OP_MOVE,    HDG_S, 4'd1);
        horz_cmd_o = mk_cmd(OP_FANFARE, HDG_W, 4'd2);
      end
      8'b???10000: begin
        vert_cmd_o = mk_cmd(OP_MOVE,    HDG_S, 4'd2);
        horz_cmd_o = mk_cmd(OP_FANFARE, HDG_W, 4'd1);
      end
      8'b??100000: begin
        vert_cmd_o = mk_cmd(OP_MOVE,    HDG_S, 4'd2);
        horz_cmd_o = mk_cmd(OP_FANFARE, HDG_E, 4'd1);
      end
      8'b?1000000: begin
        vert_cmd_o = mk_cmd(OP_MOVE,    HDG_S, 4'd1);
        horz_cmd_o = mk_cmd(OP_FANFARE, HDG_E, 4'd2);
      end
      8'b10000000: begin
        vert_cmd_o = mk_cmd(OP_MOVE,    HDG_N, 4'd1);
        horz_cmd_o = mk_cmd(OP_FANFARE, HDG_E, 4'd2);
      end
      default: begin
        vert_cmd_o = '0;
        horz_cmd_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/tour_cmd_seq.sv
// Tour command sequencer / arbiter. Idle: UART commands pass straight to
// cmd_proc. On start_tour: walks the stored moves, issuing a vertical then
// a horizontal (fanfare) leg per move, each gated on cmd_proc completion.
// Optional build macro: TOUR_ABORT_EN lets a UART opcode-F command abort
// the tour after the leg in progress completes.
module tour_cmd_seq
  import tour_cmd_pkg::*;
#(
  parameter int unsigned NUM_MOVES = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  tour_cmd_seq_if.master bus
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

  state_t      state_q, state_d;
  logic [4:0]  mv_indx_q, mv_indx_d;

  logic [15:0] vert_cmd, horz_cmd;
  logic        move_valid;

  logic [15:0] cmd_c;
  logic        cmd_rdy_c;
  logic        clr_uart_c;
  logic [7:0]  resp_c;
  logic        finishing;

  logic        abort_q;
  logic        abort_req;

  tour_move_decode u_decode (
    .move_i     (bus.move),
    .vert_cmd_o (vert_cmd),
    .horz_cmd_o (horz_cmd),
    .valid_o    (move_valid)
  );

`ifdef TOUR_ABORT_EN
  logic abort_d;

  // Abort request: opcode F from UART while touring, taken once per tour
  always_comb begin
    abort_req = (state_q != IDLE) && bus.cmd_rdy_UART &&
                (bus.cmd_UART[15:12] == OP_ABORT) && !abort_q;
    abort_d   = (state_q == IDLE) ? 1'b0 : (abort_q | abort_req);
  end

  // Abort flag register
  always_ff @(posedge clk) begin
    if (!rst_n) abort_q <= 1'b0;
    else        abort_q <= abort_d;
  end
`else
  assign abort_q   = 1'b0;
  assign abort_req = 1'b0;
`endif

  // State and move index registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mv_indx_q <= '0;
    end else begin
      state_q   <= state_d;
      mv_indx_q <= mv_indx_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    mv_indx_d  = mv_indx_q;
    cmd_c      = vert_cmd;
    cmd_rdy_c  = 1'b0;
    clr_uart_c = abort_req;
    resp_c     = RESP_POS;
    finishing  = (mv_indx_q == LAST_IDX) || abort_q;

    unique case (state_q)
      IDLE: begin
        cmd_c      = bus.cmd_UART;
        cmd_rdy_c  = bus.cmd_rdy_UART;
        clr_uart_c = bus.clr_cmd_rdy;
        resp_c     = RESP_DONE;
        if (bus.start_tour) begin
          state_d   = VERT;
          mv_indx_d = '0;
        end
      end

      // An empty move issues nothing and advances one cycle later,
      // finishing the tour exactly like a completed horizontal leg.
      VERT: begin
        cmd_c = vert_cmd;
        if (!move_valid) begin
          if (finishing) begin
            state_d   = IDLE;
            mv_indx_d = '0;
          end else begin
            mv_indx_d = mv_indx_q + 5'd1;
          end
        end else begin
          cmd_rdy_c = 1'b1;
          if (bus.clr_cmd_rdy) state_d = WAIT_V;
        end
      end

      WAIT_V: begin
        cmd_c = vert_cmd;
        if (abort_q) resp_c = RESP_DONE;
        if (bus.send_resp) begin
          if (abort_q) begin
            state_d   = IDLE;
            mv_indx_d = '0;
          end else begin
            state_d = HORZ;
          end
        end
      end

      HORZ: begin
        cmd_c     = horz_cmd;
        cmd_rdy_c = 1'b1;
        if (bus.clr_cmd_rdy) state_d = WAIT_H;
      end

      WAIT_H: begin
        cmd_c = horz_cmd;
        if (finishing) resp_c = RESP_DONE;
        if (bus.send_resp) begin
          if (finishing) begin
            state_d   = IDLE;
            mv_indx_d = '0;
          end else begin
            state_d   = VERT;
            mv_indx_d = mv_indx_q + 5'd1;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        mv_indx_d = '0;
      end
    endcase
  end

  assign bus.cmd              = cmd_c;
  assign bus.cmd_rdy          = cmd_rdy_c;
  assign bus.clr_cmd_rdy_UART = clr_uart_c;
  assign bus.resp             = resp_c;
  assign bus.mv_indx          = mv_indx_q;

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Directed bench for tour_cmd_seq with a command/response scoreboard.
module tb_tour_cmd_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tour_cmd_seq_if bus();

  tour_cmd_seq #(.NUM_MOVES(24)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Move store model: combinational lookup at the sequencer's index
  logic [7:0] store [0:31];
  assign bus.move = store[bus.mv_indx];

  int n_asserts = 0;
  int n_fail    = 0;
  int cmds_seen = 0;
  logic [15:0] cmd_q  [$];
  logic [7:0]  resp_q [$];

  // Reference move table, indexed by move bit
  logic [7:0] VH [0:7] = '{8'h00, 8'h00, 8'h00, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h00};
  logic [3:0] VS [0:7] = '{4'd2, 4'd2, 4'd1, 4'd1, 4'd2, 4'd2, 4'd1, 4'd1};
  logic [7:0] HH [0:7] = '{8'hBF, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'hBF, 8'hBF, 8'hBF};
  logic [3:0] HS [0:7] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd1, 4'd1, 4'd2, 4'd2};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [7:0] mv, output logic v,
                                output logic [15:0] vc, output logic [15:0] hc);
    v = 1'b0; vc = '0; hc = '0;
    for (int b = 7; b >= 0; b--) begin
      if (mv[b]) begin
        v  = 1'b1;
        vc = {4'h2, VH[b], VS[b]};
        hc = {4'h3, HH[b], HS[b]};
      end
    end
  endfunction

  task automatic push_tour(input int n);
    logic v;
    logic [15:0] vc, hc;
    for (int i = 0; i < n; i++) begin
      model(store[i], v, vc, hc);
      if (v) begin
        cmd_q.push_back(vc); resp_q.push_back(8'h5A);
        cmd_q.push_back(hc); resp_q.push_back((i == n - 1) ? 8'hA5 : 8'h5A);
      end
    end
  endtask

  // One leg as cmd_proc sees it; called at a negedge
  task automatic leg(input int idx, input bit do_resp);
    int k = 0;
    logic [15:0] exp_c;
    logic [7:0]  exp_r;
    #1;
    while (bus.cmd_rdy !== 1'b1 && k < 20) begin
      @(negedge clk); #1; k++;
    end
    chk("leg_rdy", 16'(bus.cmd_rdy), 16'h1);
    exp_c = (cmd_q.size() > 0) ? cmd_q.pop_front() : 16'hxxxx;
    chk("leg_cmd", bus.cmd, exp_c);
    chk("leg_idx", 16'(bus.mv_indx), 16'(idx));
    chk("uart_blocked", 16'(bus.clr_cmd_rdy_UART), 16'h0);
    cmds_seen++;
    @(negedge clk); #1;
    chk("leg_hold", bus.cmd, exp_c);
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    #1 chk("leg_drop", 16'(bus.cmd_rdy), 16'h0);
    if (do_resp) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      bus.send_resp = 1'b1;
      exp_r = (resp_q.size() > 0) ? resp_q.pop_front() : 8'hxx;
      #1 chk("leg_resp", 16'(bus.resp), 16'(exp_r));
      @(negedge clk);
      bus.send_resp = 1'b0;
    end
  endtask

  // Empty move: no request, index advances on the next cycle
  task automatic skip(input int idx);
    #1;
    chk("skip_rdy", 16'(bus.cmd_rdy), 16'h0);
    chk("skip_idx", 16'(bus.mv_indx), 16'(idx));
    @(negedge clk); #1;
    chk("skip_adv", 16'(bus.mv_indx), 16'(idx + 1));
  endtask

  task automatic run_move(input int idx);
    if (store[idx] == 8'h00) skip(idx);
    else begin
      leg(idx, 1'b1);
      leg(idx, 1'b1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bus.start_tour   = 1'b0;
    bus.cmd_UART     = 16'h1234;
    bus.cmd_rdy_UART = 1'b0;
    bus.clr_cmd_rdy  = 1'b0;
    bus.send_resp    = 1'b0;
    for (int i = 0; i < 32; i++) store[i] = 8'h01 << $urandom_range(0, 7);
    store[0] = 8'h01;
    store[5] = 8'h64;
    rst_n = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd", bus.cmd, 16'h1234);
    chk("rst_rdy", 16'(bus.cmd_rdy), 16'h0);
    chk("rst_idx", 16'(bus.mv_indx), 16'h0);
    chk("rst_resp", 16'(bus.resp), 16'h00A5);
    rst_n = 1'b1;

    // Idle pass-through
    @(negedge clk);
    bus.cmd_UART = 16'h2001; bus.cmd_rdy_UART = 1'b1;
    #1;
    chk("pt_cmd", bus.cmd, 16'h2001);
    chk("pt_rdy", 16'(bus.cmd_rdy), 16'h1);
    chk("pt_resp", 16'(bus.resp), 16'h00A5);
    chk("pt_clr0", 16'(bus.clr_cmd_rdy_UART), 16'h0);
    bus.clr_cmd_rdy = 1'b1;
    #1 chk("pt_clr1", 16'(bus.clr_cmd_rdy_UART), 16'h1);
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0; bus.cmd_rdy_UART = 1'b0;
    #1 chk("pt_clr2", 16'(bus.clr_cmd_rdy_UART), 16'h0);

    // Full tour; UART command arrives mid-tour and must wait
    cmd_q.delete(); resp_q.delete();
    push_tour(24);
    @(negedge clk); bus.start_tour = 1'b1;
    @(negedge clk); bus.start_tour = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (i == 6) begin bus.cmd_UART = 16'h2001; bus.cmd_rdy_UART = 1'b1; end
      if (i == 10) begin
        bus.start_tour = 1'b1;
        @(negedge clk);
        bus.start_tour = 1'b0;
      end
      run_move(i);
    end
    #1;
    chk("tour_cmds", 16'(cmds_seen), 16'd48);
    chk("tour_q_empty", 16'(cmd_q.size()), 16'h0);
    chk("tour_end_idx", 16'(bus.mv_indx), 16'h0);
    chk("tour_end_cmd", bus.cmd, 16'h2001);
    chk("tour_end_rdy", 16'(bus.cmd_rdy), 16'h1);
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0; bus.cmd_rdy_UART = 1'b0;

    // Empty move at index 3, then reset while waiting on a horizontal leg
    store[3] = 8'h00;
    cmd_q.delete(); resp_q.delete();
    push_tour(24);
    @(negedge clk); bus.start_tour = 1'b1;
    @(negedge clk); bus.start_tour = 1'b0;
    for (int i = 0; i < 5; i++) run_move(i);
    leg(5, 1'b1);
    leg(5, 1'b0);
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("midrst_rdy", 16'(bus.cmd_rdy), 16'h0);
    chk("midrst_idx", 16'(bus.mv_indx), 16'h0);
    chk("midrst_resp", 16'(bus.resp), 16'h00A5);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      chk("midrst_quiet", 16'(bus.cmd_rdy), 16'h0);
    end

`ifdef TOUR_ABORT_EN
    // Abort during the first vertical leg
    cmd_q.delete(); resp_q.delete();
    cmd_q.push_back(16'h2002); resp_q.push_back(8'hA5);
    @(negedge clk); bus.start_tour = 1'b1;
    @(negedge clk); bus.start_tour = 1'b0;
    bus.cmd_UART = 16'hF000; bus.cmd_rdy_UART = 1'b1;
    #1 chk("abort_clr1", 16'(bus.clr_cmd_rdy_UART), 16'h1);
    @(negedge clk); bus.cmd_rdy_UART = 1'b0;
    #1 chk("abort_clr0", 16'(bus.clr_cmd_rdy_UART), 16'h0);
    @(negedge clk);
    leg(0, 1'b1);
    #1;
    chk("abort_idx", 16'(bus.mv_indx), 16'h0);
    chk("abort_idle_cmd", bus.cmd, 16'hF000);
    repeat (3) begin
      @(negedge clk); #1;
      chk("abort_no_horz", 16'(bus.cmd_rdy), 16'h0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
